// File: rtl/reg_file.sv
// Two-read / one-write architectural register file with a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward the in-flight write to the read ports and suppress its stall.
module reg_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_W-1:0]      rs1,
   input  logic [ADDR_W-1:0]      rs2,
   output logic [DATA_W-1:0]      rd1,
   output logic [DATA_W-1:0]      rd2,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      wa,
   input  logic [DATA_W-1:0]      wd,
   input  logic                   busy_set,
   input  logic [ADDR_W-1:0]      busy_addr,
   output logic                   stall,
   output logic [2**ADDR_W-1:0]   busy_vec
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic                wr_en;
   logic                byp1;
   logic                byp2;

   // Index 0 is hardwired zero, so a write there never lands.
   assign wr_en = we && (wa != '0);

   // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      busy_d = busy_q;
      if (we)
         busy_d[wa] = 1'b0;
      // Set after clear: a new load to the retiring destination keeps the bit pending.
      if (busy_set)
         busy_d[busy_addr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: the array is reset because an asynchronous reset must clear architectural state at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= '0;
         busy_q <= '0;
      end else begin
         if (wr_en)
            regs_q[wa] <= wd;
         busy_q <= busy_d;
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign byp1 = wr_en && !rst && (rs1 == wa);
   assign byp2 = wr_en && !rst && (rs2 == wa);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (!rst) begin
         if (byp1)
            rd1 = wd;
         else if (rs1 != '0)
            rd1 = regs_q[rs1];
         if (byp2)
            rd2 = wd;
         else if (rs2 != '0)
            rd2 = regs_q[rs2];
      end
   end

   assign stall    = !rst && ((busy_q[rs1] && (rs1 != '0) && !byp1) ||
                              (busy_q[rs2] && (rs2 != '0) && !byp2));
   assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REGFILE_BYPASS_EN when defined.
module tb_reg_file;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [ADDR_W-1:0]    rs1, rs2, wa, busy_addr;
   logic [DATA_W-1:0]    rd1, rd2, wd;
   logic                 we, busy_set, stall;
   logic [2**ADDR_W-1:0] busy_vec;

   int total = 0;
   int bad   = 0;

   reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .rs1       (rs1),
      .rs2       (rs2),
      .rd1       (rd1),
      .rd2       (rd2),
      .we        (we),
      .wa        (wa),
      .wd        (wd),
      .busy_set  (busy_set),
      .busy_addr (busy_addr),
      .stall     (stall),
      .busy_vec  (busy_vec)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      we = 1'b0; wa = '0; wd = '0; busy_set = 1'b0; busy_addr = '0;
   endtask

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   initial begin
      rst = 1'b1; rs1 = '0; rs2 = '0;
      idle();
      #2;
      check("rst_busy_vec", 64'(busy_vec), 64'h0);
      check("rst_stall", 64'(stall), 64'h0);

      // Reset released; every index reads zero.
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs1 = 5'(i); rs2 = 5'(31 - i); #1;
         check($sformatf("init_rd1_%0d", i), 64'(rd1), 64'h0);
         check($sformatf("init_rd2_%0d", 31 - i), 64'(rd2), 64'h0);
      end
      check("init_stall", 64'(stall), 64'h0);
      check("init_busy_vec", 64'(busy_vec), 64'h0);

      // Write r5; same-cycle read sees old value unless bypassed.
      @(negedge clk);
      we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; rs1 = 5'd5; rs2 = 5'd0; #1;
      check("r5_same_cycle", 64'(rd1), BYP ? 64'hDEADBEEF : 64'h0);
      @(negedge clk); idle(); rs1 = 5'd5; rs2 = 5'd5; #1;
      check("r5_rd1", 64'(rd1), 64'hDEADBEEF);
      check("r5_rd2", 64'(rd2), 64'hDEADBEEF);

      // r0 write and busy_set are discarded.
      we = 1'b1; wa = 5'd0; wd = 32'h12345678; rs1 = 5'd0;
      @(negedge clk); idle(); #1;
      check("r0_read", 64'(rd1), 64'h0);
      busy_set = 1'b1; busy_addr = 5'd0;
      @(negedge clk); idle(); rs1 = 5'd0; rs2 = 5'd0; #1;
      check("r0_busy_vec", 64'(busy_vec), 64'h0);
      check("r0_stall", 64'(stall), 64'h0);

      // Busy r7 stalls a dependent read until its write-back retires it.
      busy_set = 1'b1; busy_addr = 5'd7;
      @(negedge clk); idle(); rs1 = 5'd0; rs2 = 5'd7; #1;
      check("r7_stall_rs2", 64'(stall), 64'h1);
      check("r7_busy_vec", 64'(busy_vec), 64'h80);
      rs1 = 5'd7; rs2 = 5'd5; #1;
      check("r7_stall_rs1", 64'(stall), 64'h1);
      rs1 = 5'd0; rs2 = 5'd7;
      we = 1'b1; wa = 5'd7; wd = 32'h42; #1;
      check("r7_stall_during_wb", 64'(stall), BYP ? 64'h0 : 64'h1);
      @(negedge clk); idle(); #1;
      check("r7_stall_after", 64'(stall), 64'h0);
      check("r7_rd2", 64'(rd2), 64'h42);
      check("r7_busy_clear", 64'(busy_vec), 64'h0);
      rs1 = 5'd7; rs2 = 5'd5; #1;
      check("swap_rd1", 64'(rd1), 64'h42);
      check("swap_rd2", 64'(rd2), 64'hDEADBEEF);

      // Set wins over clear on the same index.
      busy_set = 1'b1; busy_addr = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h11;
      @(negedge clk); idle(); rs1 = 5'd9; rs2 = 5'd0; #1;
      check("r9_value", 64'(rd1), 64'h11);
      check("r9_busy_vec", 64'(busy_vec), 64'h200);
      check("r9_stall", 64'(stall), 64'h1);
      we = 1'b1; wa = 5'd9; wd = 32'h22; #1;
      check("r9_inflight_rd1", 64'(rd1), BYP ? 64'h22 : 64'h11);
      check("r9_inflight_stall", 64'(stall), BYP ? 64'h0 : 64'h1);
      idle();

      // Different indices on the same edge: set r10, retire r9.
      @(negedge clk);
      busy_set = 1'b1; busy_addr = 5'd10; we = 1'b1; wa = 5'd9; wd = 32'h33;
      @(negedge clk); idle(); rs1 = 5'd9; rs2 = 5'd10; #1;
      check("split_busy_vec", 64'(busy_vec), 64'h400);
      check("split_r9", 64'(rd1), 64'h33);
      check("split_stall", 64'(stall), 64'h1);

      // Write to a non-busy register leaves its bit clear.
      we = 1'b1; wa = 5'd3; wd = 32'hAA; busy_set = 1'b1; busy_addr = 5'd4;
      @(negedge clk); idle(); rs1 = 5'd3; rs2 = 5'd4; #1;
      check("r3_value", 64'(rd1), 64'hAA);
      check("r3_r4_busy_vec", 64'(busy_vec), 64'h410);

      // Asynchronous reset between edges clears everything immediately.
      #1; rst = 1'b1; #1;
      check("async_rd1", 64'(rd1), 64'h0);
      check("async_busy_vec", 64'(busy_vec), 64'h0);
      check("async_stall", 64'(stall), 64'h0);
      we = 1'b1; wa = 5'd3; wd = 32'h55; busy_set = 1'b1; busy_addr = 5'd6; rs1 = 5'd3; #1;
      check("rst_inflight_rd1", 64'(rd1), 64'h0);
      @(negedge clk); idle(); rst = 1'b0; rs1 = 5'd3; rs2 = 5'd6; #1;
      check("post_rst_r3", 64'(rd1), 64'h0);
      check("post_rst_busy_vec", 64'(busy_vec), 64'h0);
      check("post_rst_stall", 64'(stall), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
